// File: rtl/cal_pkg.sv
// Calendar constants shared by the day counter and its month-length lookup.
package cal_pkg;

    localparam logic [5:0] MO_JAN = 6'd1;
    localparam logic [5:0] MO_FEB = 6'd2;
    localparam logic [5:0] MO_MAR = 6'd3;
    localparam logic [5:0] MO_APR = 6'd4;
    localparam logic [5:0] MO_MAY = 6'd5;
    localparam logic [5:0] MO_JUN = 6'd6;
    localparam logic [5:0] MO_JUL = 6'd7;
    localparam logic [5:0] MO_AUG = 6'd8;
    localparam logic [5:0] MO_SEP = 6'd9;
    localparam logic [5:0] MO_OCT = 6'd10;
    localparam logic [5:0] MO_NOV = 6'd11;
    localparam logic [5:0] MO_DEC = 6'd12;

    localparam logic [5:0] DAYS_31       = 6'd31;
    localparam logic [5:0] DAYS_30       = 6'd30;
    localparam logic [5:0] DAYS_FEB      = 6'd28;
    localparam logic [5:0] DAYS_FEB_LEAP = 6'd29;

    localparam logic [5:0] DAY_MIN = 6'd1;

endpackage

// File: rtl/dim_lut.sv
// Days-in-month lookup from month number and leap flag; out-of-range months read as 31.
module dim_lut
    import cal_pkg::*;
(
    input  logic [5:0] cnt_mo,
    input  logic       leap,
    output logic [5:0] dim
);

    always_comb begin
        dim = DAYS_31;
        case (cnt_mo)
            MO_JAN, MO_MAR, MO_MAY, MO_JUL,
            MO_AUG, MO_OCT, MO_DEC:         dim = DAYS_31;
            MO_APR, MO_JUN, MO_SEP, MO_NOV: dim = DAYS_30;
            MO_FEB:                         dim = leap ? DAYS_FEB_LEAP : DAYS_FEB;
            default:                        dim = DAYS_31;
        endcase
    end

endmodule

// File: rtl/cnt_day.sv
// Day-of-month counter with set-mode stepping, range clamping and month carry.
// Define CNT_DAY_FULL_GREGORIAN_EN for the full century-aware leap rule.
module cnt_day
    import cal_pkg::*;
#(
    parameter int unsigned YEAR_W    = 7,
    parameter int unsigned YEAR_BASE = 2000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pulse_1d,
    input  logic              increase_d,
    input  logic              decrease_d,
    input  logic              enable_cnt_d,
    input  logic [5:0]        cnt_mo,
    input  logic [YEAR_W-1:0] cnt_y,
    output logic [5:0]        cnt_d,
    output logic              pulse_1mo
);

    logic       leap;
    logic [5:0] dim;
    logic [5:0] cnt_d_d, cnt_d_q;

`ifdef CNT_DAY_FULL_GREGORIAN_EN
    logic [11:0] year_abs;

    always_comb begin
        year_abs = 12'(YEAR_BASE) + 12'(cnt_y);
        leap = ((year_abs % 12'd4) == 12'd0) &&
               (((year_abs % 12'd100) != 12'd0) || ((year_abs % 12'd400) == 12'd0));
    end
`else
    // Every fourth year is leap; exact for a 2000-based window up to 2099.
    logic        unused_year_hi;
    logic [31:0] unused_base;

    assign leap           = (cnt_y[1:0] == 2'b00);
    assign unused_year_hi = ^cnt_y[YEAR_W-1:2];
    assign unused_base    = YEAR_BASE;
`endif

    dim_lut u_dim_lut (
        .cnt_mo (cnt_mo),
        .leap   (leap),
        .dim    (dim)
    );

    always_comb begin
        cnt_d_d = cnt_d_q;
        if (cnt_d_q > dim) begin
            cnt_d_d = dim;
        end else if (enable_cnt_d && pulse_1d) begin
            cnt_d_d = (cnt_d_q == dim) ? DAY_MIN : cnt_d_q + 6'd1;
        end else if (!enable_cnt_d && increase_d) begin
            cnt_d_d = (cnt_d_q == dim) ? DAY_MIN : cnt_d_q + 6'd1;
        end else if (!enable_cnt_d && decrease_d) begin
            cnt_d_d = (cnt_d_q == DAY_MIN) ? dim : cnt_d_q - 6'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_d_q <= DAY_MIN;
        end else begin
            cnt_d_q <= cnt_d_d;
        end
    end

    assign cnt_d = cnt_d_q;

    // Zero-latency carry so the month advances on the same edge the day wraps.
    assign pulse_1mo = enable_cnt_d & pulse_1d & (cnt_d_q == dim) & ~rst;

endmodule

// File: doc/cnt_day.md
Name: cnt_day

Overview:
- Day-of-month counter; the producer of the pulse_1mo strobe that the month counter consumes.
- Counts 1..days-in-month on pulse_1d, with the month length taken from the current month and year (leap-aware).
- Supports manual increment/decrement in set mode.
- Clamps the day when a month or year change makes it out of range.
- Sits between the hour/day-pulse stage and the month counter in the clock/calendar datapath.

Parameters:
- YEAR_W, 7, width of cnt_y (year offset from YEAR_BASE).
- YEAR_BASE, 2000, absolute year represented by cnt_y == 0.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- pulse_1d  input  1  one-cycle strobe, one per day rollover.
- increase_d  input  1  set-mode increment request, one cycle per step.
- decrease_d  input  1  set-mode decrement request, one cycle per step.
- enable_cnt_d  input  1  1 = run mode (count pulse_1d); 0 = set mode.
- cnt_mo  input  6  current month, 1..12.
- cnt_y  input  YEAR_W  current year offset.
- cnt_d  output  6  current day, 1..31.
- pulse_1mo  output  1  one-cycle strobe to the month counter.

Behaviour:
- Reset: asynchronous; rst high forces cnt_d = 1 immediately. pulse_1mo = 0 while rst is high.
- dim (days in month) is combinational from cnt_mo and leap:
  - months 1,3,5,7,8,10,12 -> 31.
  - months 4,6,9,11 -> 30.
  - month 2 -> 29 if leap, else 28.
  - cnt_mo of 0 or >12 -> 31 (defined fallback, no X).
- Leap rule (default build): leap = (cnt_y[1:0] == 0). Valid for YEAR_BASE = 2000 over years 2000..2099.
- Register update priority, first match wins, one action per clock:
  1. Clamp: if cnt_d > dim, cnt_d <= dim. Overrides all other requests that cycle.
  2. Run: if enable_cnt_d & pulse_1d: cnt_d == dim -> 1, else cnt_d + 1.
  3. Set: if !enable_cnt_d & increase_d: cnt_d == dim -> 1, else +1.
  4. Set: else if !enable_cnt_d & decrease_d: cnt_d == 1 -> dim, else -1.
  5. Otherwise hold.
- pulse_1d while enable_cnt_d == 0 is ignored.
- increase_d and decrease_d both high -> increase wins.
- pulse_1mo = enable_cnt_d & pulse_1d & (cnt_d == dim) & !rst.
  - Combinational, zero latency: asserted in the same cycle as the final pulse_1d of the month, so the month counter advances on the same edge that wraps the day to 1.
  - Never asserted in set mode; wraps caused by increase/decrease produce no carry.
  - Suppressed in a cycle where clamp is active, because cnt_d > dim means equality fails.
- Day/month sequencing on rollover: cnt_d wraps 31 -> 1 on the same edge that cnt_mo advances. The next dim therefore sees day 1, so no clamp occurs.
- cnt_d never leaves 1..31. A value of 0 is unreachable.
- Reset mid-operation: immediate return to day 1; no pulse_1mo is emitted during or on release of reset.

Optional Feature:
- Macro: CNT_DAY_FULL_GREGORIAN_EN.
- Defined: absolute year Y = YEAR_BASE + cnt_y, computed internally at 12 bits. leap = (Y%4 == 0) & ((Y%100 != 0) | (Y%400 == 0)), so 2100 is not a leap year and 2000 is.
- Undefined: the 2-bit rule above, with no divider logic.
- Port list is identical in both builds.

Decomposition:
- Package cal_pkg holds:
  - month constants MO_JAN..MO_DEC (6-bit).
  - DAYS_31, DAYS_30, DAYS_FEB, DAYS_FEB_LEAP.
  - DAY_MIN = 1.
- Sub-module dim_lut: purely combinational, (cnt_mo, leap) -> dim.
  - Leap computation stays in cnt_day so the optional feature is confined there.

Test Plan:
- Year 2023 (cnt_y=23), month 2, cnt_d=28, enable=1, pulse_1d -> pulse_1mo=1 that cycle; cnt_d=1 next cycle.
- Year 2024 (cnt_y=24), month 2, cnt_d=28, pulse_1d -> cnt_d=29, pulse_1mo=0. A second pulse_1d -> pulse_1mo=1 and cnt_d=1.
- Set mode with cnt_d=31 and month 1; drive cnt_mo to 4 -> cnt_d=30 next cycle. increase_d asserted in that same cycle is ignored; pulse_1mo stays 0 throughout.
- Set mode, month 6, cnt_d=1, decrease_d -> cnt_d=30. Then increase_d -> cnt_d=1, with pulse_1mo=0 at every step. pulse_1d in set mode -> no change.
- Run mode, cnt_d=17: assert rst asynchronously between clock edges -> cnt_d=1 immediately and pulse_1mo=0. After release, pulse_1d -> cnt_d=2.
- With CNT_DAY_FULL_GREGORIAN_EN, cnt_y=100 (2100), month 2, cnt_d=28, pulse_1d -> pulse_1mo=1 and cnt_d=1. Without the macro, the same stimulus -> cnt_d=29.
